// File: rtl/serial_addsub_nbit_if.sv
// Operand/result bundle for the serial adder/subtractor.
// Handshake: the requester raises start together with sub/a/b/cin; the block
// accepts it on any edge where busy=0 (IDLE or DONE). While busy=1 a start is
// dropped, not queued. Completion is a one-cycle done pulse; s/cout/ovf change
// only on that edge and hold until the next completion.
interface serial_addsub_nbit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic [1:0]       dbg_state;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, s, cout, ovf, dbg_state
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, s, cout, ovf, dbg_state
   );
endinterface

// File: rtl/serial_addsub_nbit.sv
// Multi-cycle N-bit adder/subtractor: BPC operand bits per clock, LSB chunk
// first, carry held in a flip-flop between chunks. WIDTH must be >= 2 and
// BPC must divide WIDTH. The FSM state is mirrored on bus.dbg_state.
module serial_addsub_nbit #(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   serial_addsub_nbit_if.slave      bus
);
   localparam int N  = WIDTH / BPC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic [BPC:0]     w_chunk;
   logic             w_cmsb;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   // Chunk adder: one BPC-wide add reused for every chunk. The carry into the
   // top bit of the chunk is recovered as sum ^ a ^ b of that bit, which in
   // the last chunk is the carry into the operand MSB.
   always_comb begin
      w_chunk    = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_c};
      w_cmsb     = w_chunk[BPC-1] ^ r_a[BPC-1] ^ r_b[BPC-1];
      w_last     = (r_cnt == CW'(N - 1));
      w_res_next = (r_res >> BPC) | (WIDTH'(w_chunk[BPC-1:0]) << (WIDTH - BPC));
   end

   // Control FSM with datapath registers; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  // Subtraction is a + ~b + ~cin: the inverted borrow-in
                  // supplies the +1 of the two's complement of b.
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_c     <= bus.sub ? ~bus.cin : bus.cin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> BPC;
               r_b   <= r_b >> BPC;
               r_c   <= w_chunk[BPC];
               r_res <= w_res_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_s     <= w_res_next;
                  r_cout  <= w_chunk[BPC];
                  r_ovf   <= w_cmsb ^ w_chunk[BPC];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.s         = r_s;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_addsub_nbit.sv
// Bench for serial_addsub_nbit: four instances (BPC = 1, 2, 4, 8 at WIDTH = 8)
// share operand inputs and clock; each has its own start line.
module tb_serial_addsub_nbit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_v [4];
   logic       sub_d   = 1'b0;
   logic [7:0] a_d     = '0;
   logic [7:0] b_d     = '0;
   logic       cin_d   = 1'b0;
   logic       busy_v  [4];
   logic       done_v  [4];
   logic [7:0] s_v     [4];
   logic       cout_v  [4];
   logic       ovf_v   [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      serial_addsub_nbit_if #(.WIDTH(8)) bus ();
      serial_addsub_nbit #(.WIDTH(8), .BPC(1 << g)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign bus.start = start_v[g];
      assign bus.sub   = sub_d;
      assign bus.a     = a_d;
      assign bus.b     = b_d;
      assign bus.cin   = cin_d;
      assign busy_v[g] = bus.busy;
      assign done_v[g] = bus.done;
      assign s_v[g]    = bus.s;
      assign cout_v[g] = bus.cout;
      assign ovf_v[g]  = bus.ovf;
   end

   typedef struct {
      int         d;
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] es;
      logic       ec;
      logic       eo;
   } vec_t;

   vec_t vec [8];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic. cout is the carry out of the 8-bit
   // unsigned sum a + (sub ? ~b + ~cin : b + cin); ovf is "true signed result
   // does not fit in 8 bits".
   function automatic void model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output logic [7:0] s, output logic c,
                                 output logic o);
      int ua, ub, sa, sb, full, sres;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!sub) begin
         full = ua + ub + int'(cin);
         sres = sa + sb + int'(cin);
      end else begin
         full = ua + (255 - ub) + (cin ? 0 : 1);
         sres = sa - sb - int'(cin);
      end
      s = full[7:0];
      c = full[8];
      o = (sres > 127) || (sres < -128);
   endfunction

   // Present operands with start for one edge, then scramble the operand
   // inputs so the op in flight must rely on its latched copies.
   task automatic issue(input int d, input logic sub, input logic [7:0] a,
                        input logic [7:0] b, input logic cin);
      sub_d      = sub;
      a_d        = a;
      b_d        = b;
      cin_d      = cin;
      start_v[d] = 1'b1;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      a_d        = 8'($urandom);
      b_d        = 8'($urandom);
      sub_d      = 1'($urandom_range(0, 1));
      cin_d      = 1'($urandom_range(0, 1));
   endtask

   // Count edges after the start edge until done, and busy cycles on the way.
   task automatic wait_done(input int d, output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (!done_v[d] && lat < 40) begin
         if (busy_v[d]) bc++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input int d, input logic [7:0] es,
                               input logic ec, input logic eo);
      check({tag, "_s"},    int'(s_v[d]),    int'(es));
      check({tag, "_cout"}, int'(cout_v[d]), int'(ec));
      check({tag, "_ovf"},  int'(ovf_v[d]),  int'(eo));
   endtask

   initial begin
      logic [7:0] es;
      logic       ec, eo;
      int         lat, bc, n, pulses;

      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

      vec[0] = '{0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vec[1] = '{0, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vec[2] = '{2, 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
      vec[3] = '{2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      vec[4] = '{1, 1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
      vec[5] = '{3, 1'b1, 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b0, 1'b0};
      vec[6] = '{3, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vec[7] = '{1, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0};

      // Reset and its output state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 4; d++) begin
         check("rst_busy", int'(busy_v[d]), 0);
         check("rst_done", int'(done_v[d]), 0);
         check_result("rst", d, 8'h00, 1'b0, 1'b0);
      end

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         n = 8 >> vec[i].d;
         issue(vec[i].d, vec[i].sub, vec[i].a, vec[i].b, vec[i].cin);
         wait_done(vec[i].d, lat, bc);
         check("vec_latency", lat, n);
         check("vec_busy_cycles", bc, n);
         check("vec_busy_in_done", int'(busy_v[vec[i].d]), 0);
         check_result("vec", vec[i].d, vec[i].es, vec[i].ec, vec[i].eo);
         @(posedge clk);
         #1;
         check("vec_done_width", int'(done_v[vec[i].d]), 0);
      end

      // Back-to-back: start held in DONE launches the next op with no gap
      issue(2, 1'b1, 8'h80, 8'h01, 1'b0);
      wait_done(2, lat, bc);
      check_result("b2b_first", 2, 8'h7F, 1'b1, 1'b1);
      issue(2, 1'b0, 8'h10, 8'h20, 1'b0);
      check("b2b_busy_no_gap", int'(busy_v[2]), 1);
      check("b2b_done_dropped", int'(done_v[2]), 0);
      check_result("b2b_hold", 2, 8'h7F, 1'b1, 1'b1);
      wait_done(2, lat, bc);
      check("b2b_latency", lat, 2);
      check_result("b2b_second", 2, 8'h30, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // Start during RUN is ignored and not queued
      issue(0, 1'b0, 8'h12, 8'h34, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      issue(0, 1'b1, 8'hFF, 8'h77, 1'b1);
      wait_done(0, lat, bc);
      check("ign_latency", lat, 5);
      check_result("ign", 0, 8'h46, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("ign_not_queued", int'(busy_v[0]), 0);

      // Reset in RUN cycle 3 aborts without done
      issue(0, 1'b0, 8'hF0, 8'h0F, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", int'(busy_v[0]), 0);
      check("abort_done", int'(done_v[0]), 0);
      check_result("abort", 0, 8'h00, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done_v[0] || busy_v[0]) pulses++;
      end
      check("abort_no_done", pulses, 0);
      issue(0, 1'b1, 8'h20, 8'h21, 1'b0);
      wait_done(0, lat, bc);
      check("post_abort_latency", lat, 8);
      check_result("post_abort", 0, 8'hFF, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // Random sweep on every BPC
      for (int d = 0; d < 4; d++) begin
         n = 8 >> d;
         for (int k = 0; k < 1000; k++) begin
            logic       rs, rc;
            logic [7:0] ra, rb;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(rs, ra, rb, rc, es, ec, eo);
            issue(d, rs, ra, rb, rc);
            wait_done(d, lat, bc);
            check("rnd_latency", lat, n);
            check("rnd_busy_cycles", bc, n);
            check_result("rnd", d, es, ec, eo);
            @(posedge clk);
            #1;
            check("rnd_done_width", int'(done_v[d]), 0);
            check_result("rnd_hold", d, es, ec, eo);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
